// File: rtl/cdma_tx_sched.sv
// Round-robin transmit scheduler for the gold-code CDMA spreader. A granted byte is sent
// MSB-first, each bit held for CHIPS_PER_BIT chips. BITS_PER_FRAME must be 1..8.
module cdma_tx_sched #(
    parameter int NUM_USERS      = 4,
    parameter int CHIPS_PER_BIT  = 31,
    parameter int BITS_PER_FRAME = 8,
    parameter int GUARD_CYCLES   = 2,
    localparam int UW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_USERS-1:0]   valid_i,
    input  logic [8*NUM_USERS-1:0] data_i,
    input  logic [4*NUM_USERS-1:0] seed_i,
    output logic [NUM_USERS-1:0]   ready_o,
    output logic [3:0]             seed_o,
    output logic                   set_n_o,
    output logic                   signal_o,
    output logic                   tx_active_o,
    output logic [UW-1:0]          user_o,
    output logic                   err_o
);

    localparam int CW = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
    localparam int BW = (BITS_PER_FRAME > 1) ? $clog2(BITS_PER_FRAME) : 1;
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SPREAD,
        ST_REJECT,
        ST_GUARD
    } state_t;

    state_t               state_q, state_d;
    logic [UW-1:0]        rr_q, rr_d;
    logic [7:0]           shift_q, shift_d;
    logic [CW-1:0]        chip_q, chip_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [GW-1:0]        guard_q, guard_d;
    logic [NUM_USERS-1:0] ready_q, ready_d;
    logic [3:0]           seed_q, seed_d;
    logic                 set_n_q, set_n_d;
    logic                 signal_q, signal_d;
    logic                 tx_active_q, tx_active_d;
    logic [UW-1:0]        user_q, user_d;
    logic                 err_q, err_d;

    // Requests rotated so bit 0 is the user at the round-robin pointer.
    logic [NUM_USERS-1:0] req_rot;
    logic                 req_any;
    logic [UW-1:0]        grant_off;
    logic [UW:0]          grant_sum;
    logic [UW-1:0]        grant;
    logic [UW-1:0]        rr_next;
    logic [NUM_USERS-1:0] grant_onehot;
    logic [7:0]           grant_data;
    logic [3:0]           grant_seed;

    assign req_rot = NUM_USERS'({valid_i, valid_i} >> rr_q);
    assign req_any = |valid_i;

    always_comb begin
        grant_off = '0;
        for (int i = NUM_USERS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                grant_off = UW'(i);
            end
        end
    end

    assign grant_sum    = {1'b0, rr_q} + {1'b0, grant_off};
    assign grant        = (grant_sum >= (UW+1)'(NUM_USERS))
                          ? UW'(grant_sum - (UW+1)'(NUM_USERS))
                          : grant_sum[UW-1:0];
    assign rr_next      = (grant == UW'(NUM_USERS - 1)) ? '0 : grant + UW'(1);
    assign grant_onehot = NUM_USERS'(1) << grant;
    assign grant_data   = data_i[int'(grant)*8 +: 8];
    assign grant_seed   = seed_i[int'(grant)*4 +: 4];

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        shift_d     = shift_q;
        chip_d      = chip_q;
        bit_d       = bit_q;
        guard_d     = guard_q;
        ready_d     = '0;
        seed_d      = seed_q;
        set_n_d     = 1'b1;
        signal_d    = 1'b0;
        tx_active_d = 1'b0;
        user_d      = user_q;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    user_d  = grant;
                    rr_d    = rr_next;
                    shift_d = grant_data;
                    ready_d = grant_onehot;
                    if (grant_seed == 4'h0) begin
                        state_d = ST_REJECT;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        set_n_d = 1'b0;
                        seed_d  = grant_seed;
                    end
                end
            end

            ST_LOAD: begin
                state_d     = ST_SPREAD;
                chip_d      = '0;
                bit_d       = '0;
                tx_active_d = 1'b1;
                signal_d    = shift_q[BITS_PER_FRAME-1];
            end

            ST_SPREAD: begin
                if (chip_q == CW'(CHIPS_PER_BIT - 1)) begin
                    if (bit_q == BW'(BITS_PER_FRAME - 1)) begin
                        state_d = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
                        guard_d = '0;
                    end else begin
                        chip_d      = '0;
                        bit_d       = bit_q + BW'(1);
                        shift_d     = shift_q << 1;
                        tx_active_d = 1'b1;
                        signal_d    = shift_d[BITS_PER_FRAME-1];
                    end
                end else begin
                    chip_d      = chip_q + CW'(1);
                    tx_active_d = 1'b1;
                    signal_d    = shift_q[BITS_PER_FRAME-1];
                end
            end

            ST_REJECT: begin
                state_d = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
                guard_d = '0;
            end

            ST_GUARD: begin
                if (guard_q == GW'(GUARD_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            shift_q     <= '0;
            chip_q      <= '0;
            bit_q       <= '0;
            guard_q     <= '0;
            ready_q     <= '0;
            seed_q      <= '0;
            set_n_q     <= 1'b1;
            signal_q    <= 1'b0;
            tx_active_q <= 1'b0;
            user_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            shift_q     <= shift_d;
            chip_q      <= chip_d;
            bit_q       <= bit_d;
            guard_q     <= guard_d;
            ready_q     <= ready_d;
            seed_q      <= seed_d;
            set_n_q     <= set_n_d;
            signal_q    <= signal_d;
            tx_active_q <= tx_active_d;
            user_q      <= user_d;
            err_q       <= err_d;
        end
    end

    assign ready_o     = ready_q;
    assign seed_o      = seed_q;
    assign set_n_o     = set_n_q;
    assign signal_o    = signal_q;
    assign tx_active_o = tx_active_q;
    assign user_o      = user_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_cdma_tx_sched.sv
// Bench for cdma_tx_sched: a default build and a short-frame build (3 chips/bit, no guard)
// share the stimulus; a frame-level model predicts every output cycle of the selected build.
module tb_cdma_tx_sched;

    localparam int NU = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          sel;
    logic [NU-1:0] valid;
    logic [NU-1:0] cont;
    logic          rand_on;
    logic [7:0]    data_u [NU];
    logic [3:0]    seed_u [NU];
    logic [8*NU-1:0] data_bus;
    logic [4*NU-1:0] seed_bus;

    always_comb begin
        data_bus = '0;
        seed_bus = '0;
        for (int u = 0; u < NU; u++) begin
            data_bus[8*u +: 8] = data_u[u];
            seed_bus[4*u +: 4] = seed_u[u];
        end
    end

    logic [NU-1:0] ready_m, ready_s;
    logic [3:0]    seed_m, seed_s;
    logic          set_n_m, set_n_s, signal_m, signal_s, tx_m, tx_s, err_m, err_s;
    logic [1:0]    user_m, user_s;

    cdma_tx_sched u_dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data_bus), .seed_i(seed_bus),
        .ready_o(ready_m), .seed_o(seed_m), .set_n_o(set_n_m), .signal_o(signal_m),
        .tx_active_o(tx_m), .user_o(user_m), .err_o(err_m)
    );

    cdma_tx_sched #(.NUM_USERS(4), .CHIPS_PER_BIT(3), .BITS_PER_FRAME(8), .GUARD_CYCLES(0)) u_dut_short (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data_bus), .seed_i(seed_bus),
        .ready_o(ready_s), .seed_o(seed_s), .set_n_o(set_n_s), .signal_o(signal_s),
        .tx_active_o(tx_s), .user_o(user_s), .err_o(err_s)
    );

    logic [NU-1:0] o_ready;
    logic [3:0]    o_seed;
    logic          o_set_n, o_signal, o_tx, o_err;
    logic [1:0]    o_user;
    logic [13:0]   obs_vec;

    assign o_ready  = sel ? ready_s  : ready_m;
    assign o_seed   = sel ? seed_s   : seed_m;
    assign o_set_n  = sel ? set_n_s  : set_n_m;
    assign o_signal = sel ? signal_s : signal_m;
    assign o_tx     = sel ? tx_s     : tx_m;
    assign o_err    = sel ? err_s    : err_m;
    assign o_user   = sel ? user_s   : user_m;
    assign obs_vec  = {o_ready, o_err, o_set_n, o_seed, o_signal, o_tx, o_user};

    // Reference model: on each grant it lays out the whole frame as a list of expected
    // output cycles (load/reject, chips, guard plus one idle), consumed one per clock.
    typedef struct packed {
        logic [3:0] ready;
        logic       err;
        logic       set_n;
        logic [3:0] seed;
        logic       signal;
        logic       tx;
        logic [1:0] user;
    } outv_t;

    outv_t      exp_q [$];
    outv_t      exp_cur;
    outv_t      tmp_v;
    int         rr_m, g_m, cpb_m, gc_m;
    logic [3:0] seed_h;
    logic [1:0] user_h;
    bit         model_on = 1'b0;

    function automatic outv_t quiet_v();
        quiet_v = '{ready: 4'b0, err: 1'b0, set_n: 1'b1, seed: seed_h, signal: 1'b0, tx: 1'b0, user: user_h};
    endfunction

    always @(posedge clk) begin
        cpb_m = sel ? 3 : 31;
        gc_m  = sel ? 0 : 2;
        if (rst) begin
            exp_q.delete();
            rr_m    = 0;
            seed_h  = 4'h0;
            user_h  = 2'd0;
            exp_cur = quiet_v();
        end else if (exp_q.size() > 0) begin
            exp_cur = exp_q.pop_front();
        end else begin
            g_m = -1;
            for (int i = 0; i < NU; i++) begin
                if (g_m < 0 && valid[(rr_m + i) % NU]) g_m = (rr_m + i) % NU;
            end
            if (g_m < 0) begin
                exp_cur = quiet_v();
            end else begin
                rr_m   = (g_m + 1) % NU;
                user_h = 2'(g_m);
                if (seed_u[g_m] == 4'h0) begin
                    exp_cur       = quiet_v();
                    exp_cur.ready = 4'(1 << g_m);
                    exp_cur.err   = 1'b1;
                end else begin
                    seed_h        = seed_u[g_m];
                    exp_cur       = quiet_v();
                    exp_cur.ready = 4'(1 << g_m);
                    exp_cur.set_n = 1'b0;
                    for (int k = 0; k < 8 * cpb_m; k++) begin
                        tmp_v        = quiet_v();
                        tmp_v.tx     = 1'b1;
                        tmp_v.signal = data_u[g_m][7 - k / cpb_m];
                        exp_q.push_back(tmp_v);
                    end
                end
                for (int k = 0; k <= gc_m; k++) exp_q.push_back(quiet_v());
            end
        end
        model_on = 1'b1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    int cyc = 0;
    int grant_log [$];
    int grant_cyc [$];
    int run_log [$];
    logic sig_log [$];
    int ready_cnt [NU];
    int err_cnt, setn_cnt, tx_cnt, tx_run;

    task automatic clear_logs();
        grant_log.delete();
        grant_cyc.delete();
        run_log.delete();
        sig_log.delete();
        for (int u = 0; u < NU; u++) ready_cnt[u] = 0;
        err_cnt  = 0;
        setn_cnt = 0;
        tx_cnt   = 0;
        tx_run   = 0;
    endtask

    // One clock: compare against the model, log handshake activity, then drive sources.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (model_on) check("outputs", 32'(obs_vec), 32'(exp_cur));
        for (int u = 0; u < NU; u++) begin
            if (o_ready[u]) begin
                grant_log.push_back(u);
                grant_cyc.push_back(cyc);
                ready_cnt[u]++;
            end
        end
        if (o_err) err_cnt++;
        if (!o_set_n) setn_cnt++;
        if (o_tx) begin
            tx_cnt++;
            tx_run++;
            sig_log.push_back(o_signal);
        end else if (tx_run > 0) begin
            run_log.push_back(tx_run);
            tx_run = 0;
        end
        for (int u = 0; u < NU; u++) begin
            if (valid[u] && o_ready[u]) begin
                if (cont[u]) begin
                    data_u[u] = 8'($urandom_range(0, 255));
                    seed_u[u] = 4'($urandom_range(1, 15));
                end else begin
                    valid[u] = 1'b0;
                end
            end else if (rand_on && valid[u] && $urandom_range(0, 299) == 0) begin
                valid[u] = 1'b0;
            end else if (rand_on && !valid[u] && $urandom_range(0, 99) < 3) begin
                valid[u]  = 1'b1;
                data_u[u] = 8'($urandom_range(0, 255));
                seed_u[u] = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = '0;
        cont  = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic request(input int u, input logic [7:0] d, input logic [3:0] s);
        valid[u]  = 1'b1;
        data_u[u] = d;
        seed_u[u] = s;
    endtask

    int         exp_order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] pat;
    int         budget;

    initial begin
        rst     = 1'b1;
        sel     = 1'b0;
        valid   = '0;
        cont    = '0;
        rand_on = 1'b0;
        for (int u = 0; u < NU; u++) begin
            data_u[u] = 8'h00;
            seed_u[u] = 4'h0;
        end
        clear_logs();
        repeat (3) tick();
        check("reset_state", 32'(obs_vec), 32'(14'b0000_0_1_0000_0_0_00));
        rst = 1'b0;

        // Single frame from user 0: 0xA5 with seed 9.
        clear_logs();
        request(0, 8'hA5, 4'h9);
        repeat (260) tick();
        pat = 8'hA5;
        check("p1_grants", 32'(grant_log.size()), 32'd1);
        check("p1_setn_cycles", 32'(setn_cnt), 32'd1);
        check("p1_tx_cycles", 32'(tx_cnt), 32'd248);
        if (sig_log.size() == 248) begin
            for (int b = 0; b < 8; b++) begin
                check("p1_bit_first_chip", 32'(sig_log[31*b]), 32'(pat[7-b]));
                check("p1_bit_last_chip", 32'(sig_log[31*b+30]), 32'(pat[7-b]));
            end
        end

        // All users requesting continuously: round-robin order and 252-cycle spacing.
        do_reset();
        clear_logs();
        request(0, 8'h11, 4'h1);
        request(1, 8'h22, 4'h2);
        request(2, 8'h33, 4'h3);
        request(3, 8'h44, 4'h4);
        cont = 4'b1111;
        budget = 0;
        while (grant_log.size() < 5 && budget < 1400) begin
            tick();
            budget++;
        end
        cont  = '0;
        valid = '0;
        repeat (260) tick();
        check("p2_grants", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            check("p2_order", 32'(grant_log[i]), 32'(exp_order[i]));
            if (i > 0) check("p2_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd252);
        end

        // Zero seed from user 2 is rejected.
        clear_logs();
        request(2, 8'h5A, 4'h0);
        repeat (8) tick();
        check("p3_err_pulses", 32'(err_cnt), 32'd1);
        check("p3_ready2", 32'(ready_cnt[2]), 32'd1);
        check("p3_setn_cycles", 32'(setn_cnt), 32'd0);
        check("p3_tx_cycles", 32'(tx_cnt), 32'd0);

        // User 1 withdraws before grant while user 3 waits.
        clear_logs();
        request(0, 8'h3C, 4'h5);
        repeat (10) tick();
        request(1, 8'hC3, 4'h6);
        request(3, 8'h81, 4'hF);
        repeat (50) tick();
        valid[1] = 1'b0;
        repeat (600) tick();
        check("p4_ready1", 32'(ready_cnt[1]), 32'd0);
        check("p4_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) check("p4_second", 32'(grant_log[1]), 32'd3);

        // Reset in the middle of a frame; the pointer restarts at user 0.
        clear_logs();
        request(2, 8'hE7, 4'h7);
        budget = 0;
        while (tx_cnt < 100 && budget < 400) begin
            tick();
            budget++;
        end
        check("p5_reached_chip100", 32'(tx_cnt), 32'd100);
        request(1, 8'h96, 4'hA);
        request(3, 8'h69, 4'hB);
        rst = 1'b1;
        tick();
        check("p5_reset_outputs", 32'(obs_vec), 32'(14'b0000_0_1_0000_0_0_00));
        rst = 1'b0;
        clear_logs();
        repeat (600) tick();
        check("p5_ready2", 32'(ready_cnt[2]), 32'd0);
        check("p5_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("p5_first", 32'(grant_log[0]), 32'd1);
            check("p5_second", 32'(grant_log[1]), 32'd3);
        end

        // Randomized traffic with occasional resets.
        do_reset();
        clear_logs();
        rand_on = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            rst = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst     = 1'b0;
        rand_on = 1'b0;
        valid   = '0;
        repeat (300) tick();
        check("p6_had_grants", 32'(grant_log.size() > 10), 32'd1);

        // Short-frame build, no guard: 24-chip frames every 26 cycles.
        sel = 1'b1;
        do_reset();
        clear_logs();
        request(0, 8'h4D, 4'h3);
        cont[0] = 1'b1;
        repeat (110) tick();
        cont  = '0;
        valid = '0;
        repeat (40) tick();
        check("p7_grants_min", 32'(grant_log.size() >= 4), 32'd1);
        for (int i = 1; i < 4 && i < grant_log.size(); i++) begin
            check("p7_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd26);
        end
        if (run_log.size() > 0) check("p7_spread_len", 32'(run_log[0]), 32'd24);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cdma_tx_sched.md
Name: cdma_tx_sched

Overview:
- Multi-user transmit scheduler for the gold-code CDMA spreader.
- Arbitrates byte-wide transmit requests from NUM_USERS sources, round-robin.
- Loads the granted user's 4-bit seed into the gold generator via an active-low load strobe.
- Serialises the byte MSB-first, holding each bit for CHIPS_PER_BIT chip cycles on the spreader's signal input; one chip per clk_i.

Parameters:
- NUM_USERS, 4, number of requesting sources (2..8)
- CHIPS_PER_BIT, 31, chips per data bit (one gold period)
- BITS_PER_FRAME, 8, data bits per accepted word
- GUARD_CYCLES, 2, idle cycles after each frame or reject (0 allowed)

Ports:
- clk_i  in  1  chip clock; the only clock
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  NUM_USERS  per-user transmit request
- data_i  in  8*NUM_USERS  per-user byte; user u at [8u+7:8u]
- seed_i  in  4*NUM_USERS  per-user gold seed; user u at [4u+3:4u]
- ready_o  out  NUM_USERS  one-cycle accept/consume pulse to the granted user
- seed_o  out  4  seed presented to the gold generator
- set_n_o  out  1  generator load strobe, active-low
- signal_o  out  1  data bit to the spreader
- tx_active_o  out  1  high while chips are being spread
- user_o  out  clog2(NUM_USERS)  index of the current/last granted user
- err_o  out  1  one-cycle pulse: request rejected for zero seed

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i. All outputs are registered.
- Reset values: set_n_o=1; seed_o=0; signal_o=0; tx_active_o=0; user_o=0; ready_o=0; err_o=0; state=IDLE; rr pointer=0.
- rst_i mid-frame: all outputs and counters take reset values at that edge. The partial frame is discarded with no further ready_o.
- States: IDLE, LOAD, SPREAD, REJECT, GUARD.
- IDLE:
  - If any valid_i is high, grant the first set bit searching upward from the rr pointer, with wrap.
  - Latch the granted user's data_i and seed_i, set user_o=g, set pointer=(g+1) mod NUM_USERS.
  - Go to REJECT if the latched seed is 0, otherwise go to LOAD.
  - If no valid_i is high, stay in IDLE.
- LOAD (1 cycle): set_n_o=0, seed_o=latched seed, ready_o[g]=1. Next state is SPREAD.
- SPREAD:
  - tx_active_o=1; signal_o=latched bit (BITS_PER_FRAME-1-bitcnt).
  - chipcnt runs 0..CHIPS_PER_BIT-1; bitcnt increments when chipcnt wraps.
  - Exactly BITS_PER_FRAME*CHIPS_PER_BIT cycles (default 248), then GUARD.
- REJECT (1 cycle): ready_o[g]=1, err_o=1, set_n_o stays 1, tx_active_o=0. Next state is GUARD.
- GUARD: signal_o=0, tx_active_o=0 for GUARD_CYCLES cycles, then IDLE. If GUARD_CYCLES=0, go straight to IDLE.
- seed_o holds its last value outside LOAD. The generator free-runs between frames.
- Handshake:
  - The source holds valid_i high and data_i/seed_i stable until it sees ready_o.
  - The source may withdraw valid_i before grant.
  - valid_i is ignored outside IDLE.
  - The source drops valid_i in the cycle after ready_o, otherwise it is treated as a new request.
- Latency: valid_i seen high in IDLE at edge k gives LOAD (ready_o, set_n_o=0) in cycle k+1 and the first chip in cycle k+2.
- Back-to-back grant spacing (default): 1 IDLE + 1 LOAD + 248 + 2 GUARD = 252 cycles.
- Fairness: a user continuously requesting is re-granted only after every other requesting user has had one grant.

Test Plan:
- Reset, then valid_i=4'b0001, data 0xA5, seed 4'h9 -> LOAD 1 cycle after valid with set_n_o=0, seed_o=9, ready_o=0001. Then 248 cycles of tx_active_o=1 with signal_o = 1,0,1,0,0,1,0,1, each bit held 31 cycles. Then 2 GUARD cycles.
- All four valid_i held high with distinct bytes -> grant order 0,1,2,3,0. user_o matches each grant; each ready_o pulses exactly once per grant; grant spacing 252 cycles.
- User 2 seed=0, valid_i=0100 -> REJECT: ready_o=0100 and err_o=1 for one cycle, set_n_o never low, tx_active_o never high, back in IDLE after 3 cycles.
- valid_i[1] withdrawn before grant while user 3 requests -> only user 3 granted; ready_o[1] never asserted.
- rst_i high at chip 100 of SPREAD -> next cycle all outputs at reset values. A pending valid_i after rst_i falls is granted normally, starting from user 0.
- GUARD_CYCLES=0, CHIPS_PER_BIT=3 build, user 0 continuously valid -> SPREAD lasts 24 cycles. The next LOAD follows after exactly 1 IDLE cycle.
